// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipe hazard controller.
//   state_e  : controller state encoding, also exported on state_dbg
//   STATE_W  : width of the state encoding
//   CNT_W    : width of the drain/stall down-counter and the perf counter
package pipe_hazard_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_LSTALL = 3'd1,
    ST_MWAIT  = 3'd2,
    ST_SERIAL = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detector between decode and execute.
//   d_valid, d_src_1, d_src_2, d_reads_cr : decode-stage instruction info
//   x_valid, x_tgt_1, x_is_load, x_tgts_cr : execute-stage instruction info
//   hazard : decode must wait for the execute-stage result
module hazard_detect (
  input  logic       d_valid,
  input  logic [4:0] d_src_1,
  input  logic [4:0] d_src_2,
  input  logic       d_reads_cr,
  input  logic       x_valid,
  input  logic [4:0] x_tgt_1,
  input  logic       x_is_load,
  input  logic       x_tgts_cr,
  output logic       hazard
);

  logic load_use;
  logic cr_raw;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = x_is_load && (x_tgt_1 != 5'd0) &&
                    ((x_tgt_1 == d_src_1) || (x_tgt_1 == d_src_2));
  assign cr_raw   = x_tgts_cr && d_reads_cr;
  assign hazard   = d_valid && x_valid && (load_use || cr_raw);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/halt sequencer for the 5-stage pipe.
//   clk, rst, clk_en       : clock, sync active-high reset, advance enable
//   d_* / x_*              : decode/execute instruction info for hazard checks
//   pipe_empty, mem_busy   : pipe occupancy and data-memory wait
//   branch_taken, exc_wb   : control-flow redirects
//   halt_req               : halt/sleep request in decode
//   stall, flush, halt     : Mealy controls into fetch/decode/execute
//   state_dbg              : current state encoding
//   stall_cycles           : count of stalled cycles (wraps)
//
// state  | meaning
// RUN    | normal issue; hazards/redirects evaluated each cycle
// LSTALL | extra load-use stall cycles being counted down
// MWAIT  | frozen on data-memory wait
// SERIAL | waiting for the pipe to drain before a serializing op
// FLUSH  | drain window after an exception-class commit
// HALT   | pipe halted until exc_wb or reset
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        d_valid,
  input  logic [4:0]  d_src_1,
  input  logic [4:0]  d_src_2,
  input  logic        d_reads_cr,
  input  logic        d_serialize,
  input  logic        x_valid,
  input  logic [4:0]  x_tgt_1,
  input  logic        x_is_load,
  input  logic        x_tgts_cr,
  input  logic        pipe_empty,
  input  logic        mem_busy,
  input  logic        branch_taken,
  input  logic        exc_wb,
  input  logic        halt_req,
  output logic        stall,
  output logic        flush,
  output logic        halt,
  output logic [2:0]  state_dbg,
  output logic [31:0] stall_cycles
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q;
  logic               stall_c, flush_c, halt_c;
  logic               hazard;

  hazard_detect u_hazard_detect (
    .d_valid    (d_valid),
    .d_src_1    (d_src_1),
    .d_src_2    (d_src_2),
    .d_reads_cr (d_reads_cr),
    .x_valid    (x_valid),
    .x_tgt_1    (x_tgt_1),
    .x_is_load  (x_is_load),
    .x_tgts_cr  (x_tgts_cr),
    .hazard     (hazard)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    halt_c  = 1'b0;

    if (exc_wb) begin
      // The commit cycle itself is the first flush cycle of the window.
      flush_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            flush_c = 1'b1;
          end else if (mem_busy) begin
            stall_c = 1'b1;
            state_d = ST_MWAIT;
          end else if (halt_req && d_valid) begin
            stall_c = 1'b1;
            halt_c  = 1'b1;
            state_d = ST_HALT;
          end else if (d_serialize && d_valid) begin
            // An already-empty pipe lets the serializing op issue at once.
            if (!pipe_empty) begin
              stall_c = 1'b1;
              state_d = ST_SERIAL;
            end
          end else if (hazard) begin
            // The detect cycle counts as the first stall cycle.
            stall_c = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = CNT_W'(LOAD_USE_CYCLES - 1);
            end
          end
        end
        ST_LSTALL: begin
          if (branch_taken) begin
            flush_c = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end
        end
        ST_MWAIT: begin
          // A taken branch is held by its source and acted on back in RUN.
          if (mem_busy) begin
            stall_c = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_SERIAL: begin
          if (branch_taken) begin
            flush_c = 1'b1;
            state_d = ST_RUN;
          end else if (pipe_empty) begin
            state_d = ST_RUN;
          end else begin
            stall_c = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_c = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_HALT: begin
          stall_c = 1'b1;
          halt_c  = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else if (clk_en) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_q + CNT_W'(stall_c);
    end
  end

  // Reset forces a squash of everything in flight.
  assign stall        = stall_c & ~rst;
  assign flush        = flush_c | rst;
  assign halt         = halt_c & ~rst;
  assign state_dbg    = state_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int LU = 2;
  localparam int FC = 3;

  localparam int M_RUN = 0, M_LSTALL = 1, M_MWAIT = 2, M_SERIAL = 3, M_FLUSH = 4, M_HALT = 5;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        d_valid, d_reads_cr, d_serialize;
  logic [4:0]  d_src_1, d_src_2, x_tgt_1;
  logic        x_valid, x_is_load, x_tgts_cr;
  logic        pipe_empty, mem_busy, branch_taken, exc_wb, halt_req;
  logic        stall, flush, halt;
  logic [2:0]  state_dbg;
  logic [31:0] stall_cycles;

  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: current mode, cycles still owed in that mode, perf count.
  int          m_state = M_RUN;
  int          m_left  = 0;
  logic [31:0] m_sc    = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_USE_CYCLES(LU), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .d_valid(d_valid), .d_src_1(d_src_1), .d_src_2(d_src_2),
    .d_reads_cr(d_reads_cr), .d_serialize(d_serialize),
    .x_valid(x_valid), .x_tgt_1(x_tgt_1), .x_is_load(x_is_load), .x_tgts_cr(x_tgts_cr),
    .pipe_empty(pipe_empty), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .exc_wb(exc_wb), .halt_req(halt_req),
    .stall(stall), .flush(flush), .halt(halt),
    .state_dbg(state_dbg), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; clk_en = 1;
    d_valid = 0; d_src_1 = 0; d_src_2 = 0; d_reads_cr = 0; d_serialize = 0;
    x_valid = 0; x_tgt_1 = 0; x_is_load = 0; x_tgts_cr = 0;
    pipe_empty = 0; mem_busy = 0; branch_taken = 0; exc_wb = 0; halt_req = 0;
  endtask

  // Expected controls for this cycle, plus where the model goes next.
  task automatic model_eval(output logic st, output logic fl, output logic ht,
                            output int ns, output int nl);
    logic lu_dep, cr_dep, hz;
    lu_dep = x_is_load && (x_tgt_1 != 0) && ((x_tgt_1 == d_src_1) || (x_tgt_1 == d_src_2));
    cr_dep = x_tgts_cr && d_reads_cr;
    hz     = d_valid && x_valid && (lu_dep || cr_dep);
    st = 0; fl = 0; ht = 0; ns = m_state; nl = m_left;
    if (rst) begin
      fl = 1; ns = M_RUN; nl = 0;
    end else if (exc_wb) begin
      fl = 1; nl = FC - 1; ns = (nl > 0) ? M_FLUSH : M_RUN;
    end else if (m_state == M_RUN) begin
      if (branch_taken)                 fl = 1;
      else if (mem_busy)                begin st = 1; ns = M_MWAIT; end
      else if (halt_req && d_valid)     begin st = 1; ht = 1; ns = M_HALT; end
      else if (d_serialize && d_valid)  begin if (!pipe_empty) begin st = 1; ns = M_SERIAL; end end
      else if (hz)                      begin st = 1; nl = LU - 1; if (nl > 0) ns = M_LSTALL; end
    end else if (m_state == M_LSTALL) begin
      if (branch_taken) begin fl = 1; ns = M_RUN; nl = 0; end
      else begin st = 1; nl = m_left - 1; if (nl == 0) ns = M_RUN; end
    end else if (m_state == M_MWAIT) begin
      if (mem_busy) st = 1; else ns = M_RUN;
    end else if (m_state == M_SERIAL) begin
      if (branch_taken) begin fl = 1; ns = M_RUN; end
      else if (pipe_empty) ns = M_RUN;
      else st = 1;
    end else if (m_state == M_FLUSH) begin
      fl = 1; nl = m_left - 1; if (nl == 0) ns = M_RUN;
    end else begin
      st = 1; ht = 1;
    end
  endtask

  // One clock: compare every output with the model mid-cycle, then advance.
  task automatic tick();
    logic st, fl, ht;
    int   ns, nl;
    @(negedge clk);
    model_eval(st, fl, ht, ns, nl);
    chk("stall", stall, st);
    chk("flush", flush, fl);
    chk("halt", halt, ht);
    chk("state_dbg", state_dbg, m_state);
    chk("stall_cycles", stall_cycles, m_sc);
    chk("stall_flush_excl", stall & flush, 0);
    @(posedge clk);
    if (rst) begin
      m_state = ns; m_left = nl; m_sc = '0;
    end else if (clk_en) begin
      m_state = ns; m_left = nl; m_sc = m_sc + st;
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    #1; chk("rst_flush", flush, 1);
    chk("rst_stall", stall, 0);
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    do_reset();
    chk("post_rst_state", state_dbg, 0);
    chk("post_rst_sc", stall_cycles, 0);

    // Load-use: ld r3 in execute, add reading r3 in decode.
    x_valid = 1; x_is_load = 1; x_tgt_1 = 3; d_valid = 1; d_src_1 = 3;
    #1; chk("lu_stall_1", stall, 1);
    tick();
    x_valid = 0; x_is_load = 0;
    #1; chk("lu_stall_2", stall, 1);
    chk("lu_state", state_dbg, 1);
    tick();
    #1; chk("lu_released", stall, 0);
    chk("lu_sc", stall_cycles, 2);
    chk("lu_run", state_dbg, 0);
    tick();

    // Load to r0 with decode reading "nothing" is not a dependency.
    idle(); x_valid = 1; x_is_load = 1; x_tgt_1 = 0; d_valid = 1; d_src_1 = 0;
    #1; chk("r0_no_stall", stall, 0);
    tick();

    // Exception arriving mid-LSTALL.
    idle(); x_valid = 1; x_tgts_cr = 1; d_valid = 1; d_reads_cr = 1;
    tick();
    idle(); exc_wb = 1;
    #1; chk("exc_flush", flush, 1);
    chk("exc_stall", stall, 0);
    tick();
    exc_wb = 0;
    #1; chk("exc_flush_2", flush, 1);
    tick();
    #1; chk("exc_flush_3", flush, 1);
    tick();
    #1; chk("exc_done", flush, 0);
    chk("exc_run", state_dbg, 0);
    tick();

    // Serialize with the pipe busy for 4 cycles.
    idle(); d_valid = 1; d_serialize = 1; x_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("ser_stall", stall, 1);
      tick();
    end
    pipe_empty = 1; x_valid = 0;
    #1; chk("ser_release", stall, 0);
    chk("ser_state", state_dbg, 3);
    tick();
    chk("ser_run", state_dbg, 0);
    idle(); tick();

    // Memory wait with a branch resolving while frozen.
    mem_busy = 1;
    tick();
    branch_taken = 1;
    tick(); tick();
    mem_busy = 0;
    #1; chk("mw_release_stall", stall, 0);
    chk("mw_release_flush", flush, 0);
    tick();
    #1; chk("mw_branch_flush", flush, 1);
    tick();
    idle(); tick();

    // clk_en low freezes state and the perf counter.
    mem_busy = 1; clk_en = 0;
    tick(); tick();
    chk("cke_hold_state", state_dbg, 0);
    clk_en = 1; tick();
    mem_busy = 0; tick();

    // Halt, then reset out of it.
    idle(); halt_req = 1; d_valid = 1;
    tick();
    idle();
    tick();
    #1; chk("halt_held", halt, 1);
    rst = 1;
    #1; chk("halt_rst_flush", flush, 1);
    chk("halt_rst_halt", halt, 0);
    tick();
    rst = 0;
    #1; chk("halt_after_rst", halt, 0);
    chk("halt_after_rst_state", state_dbg, 0);
    chk("halt_after_rst_sc", stall_cycles, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      clk_en       = ($urandom_range(0, 7) != 0);
      exc_wb       = ($urandom_range(0, 29) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy     = ($urandom_range(0, 5) == 0);
      halt_req     = ($urandom_range(0, 19) == 0);
      d_serialize  = ($urandom_range(0, 9) == 0);
      d_valid      = ($urandom_range(0, 3) != 0);
      d_src_1      = 5'($urandom_range(0, 3));
      d_src_2      = 5'($urandom_range(0, 3));
      d_reads_cr   = ($urandom_range(0, 3) == 0);
      x_valid      = ($urandom_range(0, 3) != 0);
      x_tgt_1      = 5'($urandom_range(0, 3));
      x_is_load    = ($urandom_range(0, 1) == 0);
      x_tgts_cr    = ($urandom_range(0, 3) == 0);
      pipe_empty   = !x_valid && ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
